// File: rtl/pipe_exe_stage_if.sv
// ID/EX -> E -> EX/MEM signal bundle for the execute stage.
// master drives the ID/EX side; slave is the execute stage itself.
interface pipe_exe_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             evalid;
  logic             ewreg;
  logic             em2reg;
  logic             ewmem;
  logic [3:0]       ealuc;
  logic             ealuimm;
  logic             eshift;
  logic             ejal;
  logic             emul;
  logic [WIDTH-1:0] ea;
  logic [WIDTH-1:0] eb;
  logic [WIDTH-1:0] eimm;
  logic [WIDTH-1:0] epc4;
  logic [4:0]       ern;

  logic             estall;
  logic             mvalid;
  logic             mwreg;
  logic             mm2reg;
  logic             mwmem;
  logic [WIDTH-1:0] malu;
  logic [WIDTH-1:0] mb;
  logic [4:0]       mrn;
  logic             eovf;

  modport master (
    output evalid, ewreg, em2reg, ewmem, ealuc, ealuimm, eshift, ejal, emul,
    output ea, eb, eimm, epc4, ern,
    input  estall, mvalid, mwreg, mm2reg, mwmem, malu, mb, mrn, eovf
  );

  modport slave (
    input  evalid, ewreg, em2reg, ewmem, ealuc, ealuimm, eshift, ejal, emul,
    input  ea, eb, eimm, epc4, ern,
    output estall, mvalid, mwreg, mm2reg, mwmem, malu, mb, mrn, eovf
  );
endinterface

// File: rtl/pipe_exe_stage.sv
// Execute stage: single-cycle ALU plus iterative shift-add multiplier feeding EX/MEM.
// Optional signed-overflow trap on add/sub enabled by defining EXE_OVF_TRAP_EN.
module pipe_exe_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_CYC = 32
) (
  input logic             clk,
  input logic             clr,
  pipe_exe_stage_if.slave bus
);
  localparam int unsigned CntW = $clog2(MUL_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYC - 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mvalid_q, mvalid_d, mwreg_q, mwreg_d, mm2reg_q, mm2reg_d, mwmem_q, mwmem_d;
  logic [WIDTH-1:0] malu_q, malu_d, mb_q, mb_d;
  logic [4:0]       mrn_q, mrn_d;
  logic             stall;

  logic [WIDTH-1:0] opa, opb, sum, diff, alu, acc_next;
  logic [4:0]       sh;
  logic             ovf;

  assign opa  = bus.eshift ? {{(WIDTH-5){1'b0}}, bus.eimm[10:6]} : bus.ea;
  assign opb  = bus.ealuimm ? bus.eimm : bus.eb;
  assign sh   = opa[4:0];
  assign sum  = opa + opb;
  assign diff = opa - opb;

  always_comb begin
    alu = sum;
    unique case (bus.ealuc[1:0])
      2'b00: alu = bus.ealuc[2] ? diff : sum;
      2'b01: alu = bus.ealuc[2] ? (opa | opb) : (opa & opb);
      2'b10: alu = bus.ealuc[2] ? {opb[15:0], 16'b0} : (opa ^ opb);
      2'b11: begin
        if (!bus.ealuc[2])     alu = opb << sh;
        else if (bus.ealuc[3]) alu = WIDTH'($signed(opb) >>> sh);
        else                   alu = opb >> sh;
      end
      default: alu = sum;
    endcase
  end

`ifdef EXE_OVF_TRAP_EN
  logic is_arith, ovf_add, ovf_sub;
  assign is_arith = bus.evalid & ~bus.emul & ~bus.ejal & (bus.ealuc[1:0] == 2'b00);
  assign ovf_add  = (opa[WIDTH-1] == opb[WIDTH-1]) & (sum[WIDTH-1] != opa[WIDTH-1]);
  assign ovf_sub  = (opa[WIDTH-1] != opb[WIDTH-1]) & (diff[WIDTH-1] != opa[WIDTH-1]);
  assign ovf      = is_arith & (bus.ealuc[2] ? ovf_sub : ovf_add);
`else
  assign ovf = 1'b0;
`endif

  // Final iteration's partial product is folded in combinationally at completion.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    mvalid_d = 1'b0;
    mwreg_d  = 1'b0;
    mm2reg_d = 1'b0;
    mwmem_d  = 1'b0;
    malu_d   = malu_q;
    mb_d     = mb_q;
    mrn_d    = mrn_q;
    unique case (state_q)
      StIdle: begin
        if (bus.evalid && bus.emul) begin
          mcand_d  = bus.ea;
          mplier_d = bus.eb;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StMul;
          stall    = 1'b1;
        end else if (bus.evalid) begin
          mvalid_d = 1'b1;
          mwreg_d  = bus.ewreg & ~ovf;
          mm2reg_d = bus.em2reg;
          mwmem_d  = bus.ewmem;
          malu_d   = bus.ejal ? bus.epc4 + WIDTH'(4) : alu;
          mb_d     = bus.eb;
          mrn_d    = bus.ejal ? 5'd31 : bus.ern;
        end
      end
      StMul: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d  = StIdle;
          mvalid_d = 1'b1;
          mwreg_d  = bus.ewreg;
          mm2reg_d = bus.em2reg;
          mwmem_d  = bus.ewmem;
          malu_d   = acc_next;
          mb_d     = bus.eb;
          mrn_d    = bus.ern;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mvalid_q <= 1'b0;
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mwmem_q  <= 1'b0;
      malu_q   <= '0;
      mb_q     <= '0;
      mrn_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mvalid_q <= mvalid_d;
      mwreg_q  <= mwreg_d;
      mm2reg_q <= mm2reg_d;
      mwmem_q  <= mwmem_d;
      malu_q   <= malu_d;
      mb_q     <= mb_d;
      mrn_q    <= mrn_d;
    end
  end

  assign bus.estall = stall & ~clr;
  assign bus.mvalid = mvalid_q;
  assign bus.mwreg  = mwreg_q;
  assign bus.mm2reg = mm2reg_q;
  assign bus.mwmem  = mwmem_q;
  assign bus.malu   = malu_q;
  assign bus.mb     = mb_q;
  assign bus.mrn    = mrn_q;
  assign bus.eovf   = ovf;
endmodule

// File: tb/tb_pipe_exe_stage.sv
// Randomised bench for pipe_exe_stage against a behavioural model of the execute stage.
// Honours EXE_OVF_TRAP_EN the same way the design does.
module tb_pipe_exe_stage;
`ifdef EXE_OVF_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  typedef struct packed {
    logic        valid, wreg, m2reg, wmem;
    logic [3:0]  aluc;
    logic        aluimm, shift, jal, mul;
    logic [31:0] a, b, imm, pc4;
    logic [4:0]  rn;
  } ins_t;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  pipe_exe_stage_if #(.WIDTH(32)) bus ();

  pipe_exe_stage #(.WIDTH(32), .MUL_CYC(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic        exp_stall, exp_eovf, exp_valid, exp_wreg, exp_m2reg, exp_wmem;
  logic [31:0] exp_alu, exp_mb;
  logic [4:0]  exp_rn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("estall", 32'(bus.estall), 32'(exp_stall));
      chk("eovf", 32'(bus.eovf), 32'(exp_eovf));
      chk("mvalid", 32'(bus.mvalid), 32'(exp_valid));
      chk("mwreg", 32'(bus.mwreg), 32'(exp_wreg));
      chk("mm2reg", 32'(bus.mm2reg), 32'(exp_m2reg));
      chk("mwmem", 32'(bus.mwmem), 32'(exp_wmem));
      if (exp_valid) begin
        chk("malu", bus.malu, exp_alu);
        chk("mb", bus.mb, exp_mb);
        chk("mrn", 32'(bus.mrn), 32'(exp_rn));
      end
    end
  end

  function automatic logic [31:0] op_a(input ins_t i);
    return i.shift ? 32'(i.imm[10:6]) : i.a;
  endfunction

  function automatic logic [31:0] op_b(input ins_t i);
    return i.aluimm ? i.imm : i.b;
  endfunction

  function automatic logic [31:0] mdl_alu(input ins_t i);
    logic [31:0] a, b;
    a = op_a(i);
    b = op_b(i);
    if (i.jal) return i.pc4 + 32'd4;
    casez (i.aluc)
      4'b?000: return a + b;
      4'b?100: return a - b;
      4'b?001: return a & b;
      4'b?101: return a | b;
      4'b?010: return a ^ b;
      4'b?110: return {b[15:0], 16'h0000};
      4'b0111: return b >> a[4:0];
      4'b1111: return 32'($signed(b) >>> a[4:0]);
      default: return b << a[4:0];
    endcase
  endfunction

  // True signed overflow via wide arithmetic.
  function automatic bit mdl_ovf(input ins_t i);
    longint sa, sb, r;
    if (!i.valid || i.mul || i.jal || i.aluc[1:0] != 2'b00) return 1'b0;
    sa = longint'($signed(op_a(i)));
    sb = longint'($signed(op_b(i)));
    r  = i.aluc[2] ? sa - sb : sa + sb;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i = '0;
    return i;
  endfunction

  task automatic drive(input ins_t i);
    bus.evalid  = i.valid;
    bus.ewreg   = i.wreg;
    bus.em2reg  = i.m2reg;
    bus.ewmem   = i.wmem;
    bus.ealuc   = i.aluc;
    bus.ealuimm = i.aluimm;
    bus.eshift  = i.shift;
    bus.ejal    = i.jal;
    bus.emul    = i.mul;
    bus.ea      = i.a;
    bus.eb      = i.b;
    bus.eimm    = i.imm;
    bus.epc4    = i.pc4;
    bus.ern     = i.rn;
  endtask

  task automatic set_bubble();
    exp_valid = 1'b0;
    exp_wreg  = 1'b0;
    exp_m2reg = 1'b0;
    exp_wmem  = 1'b0;
  endtask

  // Presents one instruction and advances until it has landed in M.
  task automatic issue(input ins_t i);
    drive(i);
    exp_eovf = Trap && mdl_ovf(i);
    if (i.valid && i.mul) begin
      for (int k = 0; k < 32; k++) begin
        exp_stall = 1'b1;
        @(posedge clk); #1;
        set_bubble();
      end
      exp_stall = 1'b0;
      @(posedge clk); #1;
      exp_valid = 1'b1;
      exp_wreg  = i.wreg;
      exp_m2reg = i.m2reg;
      exp_wmem  = i.wmem;
      exp_alu   = i.a * i.b;
      exp_mb    = i.b;
      exp_rn    = i.rn;
    end else begin
      exp_stall = 1'b0;
      @(posedge clk); #1;
      if (i.valid) begin
        exp_valid = 1'b1;
        exp_wreg  = i.wreg && !(Trap && mdl_ovf(i));
        exp_m2reg = i.m2reg;
        exp_wmem  = i.wmem;
        exp_alu   = mdl_alu(i);
        exp_mb    = i.b;
        exp_rn    = i.jal ? 5'd31 : i.rn;
      end else begin
        set_bubble();
      end
    end
  endtask

  function automatic logic [31:0] rand_word();
    unique case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    logic [3:0] codes [9];
    codes = '{4'h0, 4'h4, 4'h1, 4'h5, 4'h2, 4'h6, 4'h3, 4'h7, 4'hF};
    i        = '0;
    i.valid  = ($urandom_range(0, 99) < 85);
    i.wreg   = 1'($urandom);
    i.m2reg  = 1'($urandom);
    i.wmem   = 1'($urandom);
    i.aluc   = codes[$urandom_range(0, 8)];
    if (i.aluc[1:0] != 2'b11) i.aluc[3] = 1'($urandom);
    i.aluimm = ($urandom_range(0, 3) == 0);
    i.shift  = ($urandom_range(0, 3) == 0);
    i.mul    = ($urandom_range(0, 9) == 0);
    i.jal    = !i.mul && ($urandom_range(0, 9) == 0);
    i.a      = rand_word();
    i.b      = rand_word();
    i.imm    = rand_word();
    i.pc4    = $urandom;
    i.rn     = 5'($urandom);
    return i;
  endfunction

  initial begin
    ins_t t;
    clr = 1'b1;
    drive(nop());
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mvalid", 32'(bus.mvalid), 32'd0);
    chk("rst_mwreg", 32'(bus.mwreg), 32'd0);
    chk("rst_mm2reg", 32'(bus.mm2reg), 32'd0);
    chk("rst_mwmem", 32'(bus.mwmem), 32'd0);
    chk("rst_malu", bus.malu, 32'd0);
    chk("rst_mb", bus.mb, 32'd0);
    chk("rst_mrn", 32'(bus.mrn), 32'd0);
    chk("rst_estall", 32'(bus.estall), 32'd0);
    clr = 1'b0;
    exp_stall = 1'b0;
    exp_eovf  = 1'b0;
    set_bubble();
    exp_alu = '0; exp_mb = '0; exp_rn = '0;
    chk_en = 1'b1;

    t = nop(); t.valid = 1; t.wreg = 1; t.a = 5; t.b = 3; t.rn = 8;
    issue(t);
    chk("add_lit_malu", bus.malu, 32'd8);
    chk("add_lit_mrn", 32'(bus.mrn), 32'd8);
    chk("add_lit_mwreg", 32'(bus.mwreg), 32'd1);

    t = nop(); t.valid = 1; t.mul = 1; t.wreg = 1; t.a = 7; t.b = 6; t.rn = 3;
    issue(t);
    chk("mul_lit", bus.malu, 32'd42);
    chk("mul_lit_mvalid", 32'(bus.mvalid), 32'd1);

    t.a = 32'hFFFF_FFFF; t.b = 2;
    issue(t);
    chk("mul_wrap_lit", bus.malu, 32'hFFFF_FFFE);
    t.a = 3; t.b = 4;
    issue(t);
    chk("mul_b2b_lit", bus.malu, 32'd12);

    t = nop(); t.valid = 1; t.wreg = 1; t.jal = 1; t.pc4 = 32'h100; t.rn = 5;
    issue(t);
    chk("jal_lit_malu", bus.malu, 32'h104);
    chk("jal_lit_mrn", 32'(bus.mrn), 32'd31);

    t = nop(); t.valid = 1; t.shift = 1; t.aluc = 4'hF; t.imm = 32'h0000_0100; t.b = 32'h8000_0000;
    issue(t);
    chk("sra_lit", bus.malu, 32'hF800_0000);

    t = nop(); t.valid = 1; t.wreg = 1; t.a = 32'h7FFF_FFFF; t.b = 1; t.rn = 9;
    drive(t);
    #1;
`ifdef EXE_OVF_TRAP_EN
    chk("ovf_lit_eovf", 32'(bus.eovf), 32'd1);
`else
    chk("ovf_lit_eovf", 32'(bus.eovf), 32'd0);
`endif
    issue(t);
`ifdef EXE_OVF_TRAP_EN
    chk("ovf_lit_mwreg", 32'(bus.mwreg), 32'd0);
`else
    chk("ovf_lit_mwreg", 32'(bus.mwreg), 32'd1);
    chk("ovf_lit_malu", bus.malu, 32'h8000_0000);
`endif

    // Abort a multiply once its iteration counter reaches 10.
    t = nop(); t.valid = 1; t.mul = 1; t.wreg = 1; t.a = 9; t.b = 9; t.rn = 4;
    drive(t);
    exp_eovf = 1'b0;
    exp_stall = 1'b1;
    repeat (11) begin
      @(posedge clk); #1;
      set_bubble();
    end
    chk_en = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    drive(nop());
    #1;
    chk("abort_mvalid", 32'(bus.mvalid), 32'd0);
    chk("abort_mwreg", 32'(bus.mwreg), 32'd0);
    chk("abort_estall", 32'(bus.estall), 32'd0);
    exp_stall = 1'b0;
    set_bubble();
    chk_en = 1'b1;
    repeat (35) issue(nop());

    for (int n = 0; n < 300; n++) issue(rand_ins());

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
